// File: rtl/tlc_pkg.sv
// -----------------------------------------------------------------------------
// tlc_pkg
// Shared definitions for the traffic-light phase arbiter:
//   - tlc_phase_e   : phase/state encoding, also driven on the phase output
//   - TLC_NUM_STATES: number of legal phases (encoding 7 is never legal)
//   - LAMP_*        : bit positions inside a per-side {G,Y,R} lamp vector
// -----------------------------------------------------------------------------
package tlc_pkg;

  localparam int TLC_NUM_STATES = 7;
  localparam int PHASE_W        = $clog2(TLC_NUM_STATES);

  typedef enum logic [PHASE_W-1:0] {
    PH_NS_GREEN  = 3'd0,
    PH_NS_YELLOW = 3'd1,
    PH_ALL_RED_A = 3'd2,
    PH_EW_GREEN  = 3'd3,
    PH_EW_YELLOW = 3'd4,
    PH_ALL_RED_B = 3'd5,
    PH_PED_WALK  = 3'd6
  } tlc_phase_e;

  localparam int LAMP_R = 0;
  localparam int LAMP_Y = 1;
  localparam int LAMP_G = 2;
  localparam int LAMP_W = 3;

endpackage

// File: rtl/tlc_phase_timer.sv
// -----------------------------------------------------------------------------
// tlc_phase_timer
// Interval counter for the phase arbiter. Counts up once per cycle, holds
// when it reaches i_sat, and returns to zero on i_clr.
// Ports:
//   clk      : clock, rising edge
//   i_rst_n  : asynchronous active-low reset (count -> 0)
//   i_clr    : synchronous clear, takes priority over counting
//   i_sat    : saturation value; the count never advances past it
//   o_count  : current count
// -----------------------------------------------------------------------------
module tlc_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_sat,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (r_count < i_sat) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/tlc_phase_arbiter.sv
// -----------------------------------------------------------------------------
// tlc_phase_arbiter
// Demand-actuated right-of-way controller for a two-road intersection.
// Grants green to NS or EW from detector requests with min/max green,
// yellow and all-red clearance, plus an optional pedestrian walk phase.
// Build option: define TLC_PED_EN to include the pedestrian logic; without
// it ped_req is ignored and ped_walk/ped_pending are held low.
// Ports:
//   clk                 : clock, rising edge
//   rst                 : asynchronous active-low reset
//   ns_req / ew_req     : vehicle detectors (level)
//   ped_req             : pedestrian button (pulse is enough)
//   NS_R/NS_Y/NS_G      : NS lamps (one-hot)
//   EW_R/EW_Y/EW_G      : EW lamps (one-hot)
//   ped_walk            : walk indication
//   ped_pending         : latched pedestrian request
//   phase               : current state encoding
// -----------------------------------------------------------------------------
module tlc_phase_arbiter
  import tlc_pkg::*;
#(
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 20,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 1,
  parameter int WALK      = 6,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ns_req,
  input  logic       ew_req,
  input  logic       ped_req,
  output logic       NS_R,
  output logic       NS_G,
  output logic       NS_Y,
  output logic       EW_R,
  output logic       EW_G,
  output logic       EW_Y,
  output logic       ped_walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] C_MIN_M1  = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] C_MAX_M1  = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] C_YEL_M1  = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] C_AR_M1   = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] C_WALK_M1 = CNT_W'(WALK - 1);

  tlc_phase_e        r_state;
  tlc_phase_e        w_state_next;
  logic [CNT_W-1:0]  w_timer;
  logic [CNT_W-1:0]  w_sat;
  logic              w_in_green;
  logic              w_min_done;
  logic              w_max_done;
  logic              w_yel_done;
  logic              w_ar_done;
  logic              w_walk_done;
  logic              w_ped_pend;
  logic [LAMP_W-1:0] w_ns_lamps;
  logic [LAMP_W-1:0] w_ew_lamps;

  // Timer restarts whenever the phase changes; in green it parks at
  // MAX_GREEN-1 so the max-green test stays true while demand persists.
  assign w_in_green = (r_state == PH_NS_GREEN) || (r_state == PH_EW_GREEN);
  assign w_sat      = w_in_green ? C_MAX_M1 : '1;

  tlc_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .i_rst_n (rst),
    .i_clr   (w_state_next != r_state),
    .i_sat   (w_sat),
    .o_count (w_timer)
  );

  assign w_min_done  = (w_timer >= C_MIN_M1);
  assign w_max_done  = (w_timer == C_MAX_M1);
  assign w_yel_done  = (w_timer == C_YEL_M1);
  assign w_ar_done   = (w_timer == C_AR_M1);
  assign w_walk_done = (w_timer == C_WALK_M1);

`ifdef TLC_PED_EN
  logic r_ped_pending;
  logic r_next_dir;    // 1: walk is followed by EW green, 0: by NS green
  logic w_enter_walk;

  assign w_enter_walk = (w_state_next == PH_PED_WALK) && (r_state != PH_PED_WALK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ped_pending <= 1'b0;
      r_next_dir    <= 1'b1;
    end else begin
      // A new press on the entry edge must survive the clear.
      if (ped_req) begin
        r_ped_pending <= 1'b1;
      end else if (w_enter_walk) begin
        r_ped_pending <= 1'b0;
      end
      if (w_enter_walk) begin
        r_next_dir <= (r_state == PH_ALL_RED_A);
      end
    end
  end

  assign w_ped_pend = r_ped_pending;
  assign ped_walk   = (r_state == PH_PED_WALK);
`else
  logic w_unused_ped;
  assign w_unused_ped = ped_req ^ w_walk_done;
  assign w_ped_pend   = 1'b0;
  assign ped_walk     = 1'b0;
`endif

  assign ped_pending = w_ped_pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= PH_NS_GREEN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      PH_NS_GREEN:
        if (w_min_done && (ew_req || w_ped_pend) && (!ns_req || w_max_done))
          w_state_next = PH_NS_YELLOW;
      PH_NS_YELLOW:
        if (w_yel_done) w_state_next = PH_ALL_RED_A;
      PH_ALL_RED_A:
        if (w_ar_done) w_state_next = w_ped_pend ? PH_PED_WALK : PH_EW_GREEN;
      PH_EW_GREEN:
        if (w_min_done && (ns_req || w_ped_pend) && (!ew_req || w_max_done))
          w_state_next = PH_EW_YELLOW;
      PH_EW_YELLOW:
        if (w_yel_done) w_state_next = PH_ALL_RED_B;
      PH_ALL_RED_B:
        if (w_ar_done) w_state_next = w_ped_pend ? PH_PED_WALK : PH_NS_GREEN;
`ifdef TLC_PED_EN
      PH_PED_WALK:
        if (w_walk_done) w_state_next = r_next_dir ? PH_EW_GREEN : PH_NS_GREEN;
`endif
      default:
        w_state_next = PH_NS_GREEN;
    endcase
  end

  // Moore lamp decode; anything not green/yellow is red on that side.
  always_comb begin
    w_ns_lamps = '0;
    w_ew_lamps = '0;
    case (r_state)
      PH_NS_GREEN:  begin w_ns_lamps[LAMP_G] = 1'b1; w_ew_lamps[LAMP_R] = 1'b1; end
      PH_NS_YELLOW: begin w_ns_lamps[LAMP_Y] = 1'b1; w_ew_lamps[LAMP_R] = 1'b1; end
      PH_EW_GREEN:  begin w_ns_lamps[LAMP_R] = 1'b1; w_ew_lamps[LAMP_G] = 1'b1; end
      PH_EW_YELLOW: begin w_ns_lamps[LAMP_R] = 1'b1; w_ew_lamps[LAMP_Y] = 1'b1; end
      default:      begin w_ns_lamps[LAMP_R] = 1'b1; w_ew_lamps[LAMP_R] = 1'b1; end
    endcase
  end

  assign NS_R  = w_ns_lamps[LAMP_R];
  assign NS_Y  = w_ns_lamps[LAMP_Y];
  assign NS_G  = w_ns_lamps[LAMP_G];
  assign EW_R  = w_ew_lamps[LAMP_R];
  assign EW_Y  = w_ew_lamps[LAMP_Y];
  assign EW_G  = w_ew_lamps[LAMP_G];
  assign phase = r_state;

endmodule

// File: tb/tb_tlc_phase_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tlc_phase_arbiter
// Directed bench for tlc_phase_arbiter with default parameters. Cycle n is
// the interval ending at the n-th rising edge after rst is released; inputs
// set in cycle n are sampled at that edge.
// -----------------------------------------------------------------------------
module tb_tlc_phase_arbiter;

  logic       clk;
  logic       rst;
  logic       ns_req, ew_req, ped_req;
  logic       NS_R, NS_G, NS_Y, EW_R, EW_G, EW_Y;
  logic       ped_walk, ped_pending;
  logic [2:0] phase;

  int checks   = 0;
  int failures = 0;

  tlc_phase_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .ns_req      (ns_req),
    .ew_req      (ew_req),
    .ped_req     (ped_req),
    .NS_R        (NS_R),
    .NS_G        (NS_G),
    .NS_Y        (NS_Y),
    .EW_R        (EW_R),
    .EW_G        (EW_G),
    .EW_Y        (EW_Y),
    .ped_walk    (ped_walk),
    .ped_pending (ped_pending),
    .phase       (phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {NS_R,NS_Y,NS_G,EW_R,EW_Y,EW_G} expected for a given phase
  function automatic logic [5:0] exp_lamps(input int ph);
    case (ph)
      0:       return 6'b001_100;
      1:       return 6'b010_100;
      3:       return 6'b100_001;
      4:       return 6'b100_010;
      default: return 6'b100_100;
    endcase
  endfunction

  function automatic logic [5:0] lamps();
    return {NS_R, NS_Y, NS_G, EW_R, EW_Y, EW_G};
  endfunction

  // Leaves the bench at a falling edge at the start of cycle 0.
  task automatic do_reset();
    rst = 1'b0; ns_req = 1'b0; ew_req = 1'b0; ped_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; ns_req = 1'b0; ew_req = 1'b1; ped_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (phase !== 3'd0) begin
      failures++; $display("FAIL reset_phase got=%0d exp=0", phase);
    end
    checks++;
    if (lamps() !== 6'b001_100) begin
      failures++; $display("FAIL reset_lamps got=%b exp=001100", lamps());
    end
    checks++;
    if ({ped_walk, ped_pending} !== 2'b00) begin
      failures++; $display("FAIL reset_ped got=%b exp=00", {ped_walk, ped_pending});
    end
    $display("test_reset done");
  endtask

  task automatic test_idle();
    int bad = 0;
    do_reset();
    for (int c = 0; c < 100; c++) begin
      #1;
      checks++;
      if (phase !== 3'd0 || lamps() !== 6'b001_100) begin
        failures++; bad++;
        $display("FAIL idle cyc=%0d phase=%0d lamps=%b exp phase=0 lamps=001100", c, phase, lamps());
      end
      @(negedge clk);
    end
    $display("test_idle done bad=%0d", bad);
  endtask

  task automatic test_ew_demand();
    int ex;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      ew_req = (c < 12);
      ns_req = (c >= 12);
      if      (c < 8)   ex = 0;
      else if (c < 11)  ex = 1;
      else if (c == 11) ex = 2;
      else if (c < 20)  ex = 3;
      else if (c < 23)  ex = 4;
      else if (c == 23) ex = 5;
      else              ex = 0;
      #1;
      checks++;
      if (phase !== 3'(ex) || lamps() !== exp_lamps(ex)) begin
        failures++;
        $display("FAIL ew_demand cyc=%0d phase=%0d lamps=%b exp phase=%0d lamps=%b",
                 c, phase, lamps(), ex, exp_lamps(ex));
      end
      @(negedge clk);
    end
    $display("test_ew_demand done");
  endtask

  task automatic test_both_demand();
    int ex, p;
    do_reset();
    ns_req = 1'b1; ew_req = 1'b1;
    for (int c = 0; c < 110; c++) begin
      p = c % 48;
      if      (p < 20)  ex = 0;
      else if (p < 23)  ex = 1;
      else if (p == 23) ex = 2;
      else if (p < 44)  ex = 3;
      else if (p < 47)  ex = 4;
      else              ex = 5;
      #1;
      checks++;
      if (phase !== 3'(ex) || lamps() !== exp_lamps(ex)) begin
        failures++;
        $display("FAIL both_demand cyc=%0d phase=%0d lamps=%b exp phase=%0d lamps=%b",
                 c, phase, lamps(), ex, exp_lamps(ex));
      end
      checks++;
      if ((NS_G | NS_Y) && (EW_G | EW_Y)) begin
        failures++;
        $display("FAIL both_overlap cyc=%0d lamps=%b exp no conflict", c, lamps());
      end
      @(negedge clk);
    end
    $display("test_both_demand done");
  endtask

`ifdef TLC_PED_EN
  task automatic test_ped_walk();
    int ex;
    logic exp_pend, exp_walk;
    do_reset();
    for (int c = 0; c < 24; c++) begin
      ped_req = (c == 2);
      if      (c < 8)   ex = 0;
      else if (c < 11)  ex = 1;
      else if (c == 11) ex = 2;
      else if (c < 18)  ex = 6;
      else              ex = 3;
      exp_pend = (c >= 3) && (c <= 11);
      exp_walk = (c >= 12) && (c <= 17);
      #1;
      checks++;
      if (phase !== 3'(ex) || lamps() !== exp_lamps(ex)) begin
        failures++;
        $display("FAIL ped_phase cyc=%0d phase=%0d lamps=%b exp phase=%0d lamps=%b",
                 c, phase, lamps(), ex, exp_lamps(ex));
      end
      checks++;
      if (ped_pending !== exp_pend || ped_walk !== exp_walk) begin
        failures++;
        $display("FAIL ped_flags cyc=%0d pend=%b walk=%b exp pend=%b walk=%b",
                 c, ped_pending, ped_walk, exp_pend, exp_walk);
      end
      @(negedge clk);
    end
    ped_req = 1'b0;
    $display("test_ped_walk done");
  endtask
`else
  task automatic test_ped_ignored();
    do_reset();
    for (int c = 0; c < 40; c++) begin
      ped_req = (c % 5 == 2);
      #1;
      checks++;
      if (phase !== 3'd0 || lamps() !== 6'b001_100 || ped_walk !== 1'b0 || ped_pending !== 1'b0) begin
        failures++;
        $display("FAIL ped_ignored cyc=%0d phase=%0d lamps=%b walk=%b pend=%b exp 0 001100 0 0",
                 c, phase, lamps(), ped_walk, ped_pending);
      end
      @(negedge clk);
    end
    ped_req = 1'b0;
    $display("test_ped_ignored done");
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      ew_req = (c < 12);
      ns_req = (c >= 12);
`ifdef TLC_PED_EN
      ped_req = (c == 14);
`endif
      @(negedge clk);
    end
    ped_req = 1'b0;
    // now in cycle 20: EW_YELLOW
    #1;
    checks++;
    if (phase !== 3'd4) begin
      failures++; $display("FAIL async_pre_phase got=%0d exp=4", phase);
    end
`ifdef TLC_PED_EN
    checks++;
    if (ped_pending !== 1'b1) begin
      failures++; $display("FAIL async_pre_pend got=%b exp=1", ped_pending);
    end
`endif
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (phase !== 3'd0 || lamps() !== 6'b001_100 || ped_pending !== 1'b0) begin
      failures++;
      $display("FAIL async_reset phase=%0d lamps=%b pend=%b exp 0 001100 0",
               phase, lamps(), ped_pending);
    end
    @(negedge clk);
    rst = 1'b1;
    $display("test_async_reset done");
  endtask

  initial begin
    rst = 1'b0; ns_req = 1'b0; ew_req = 1'b0; ped_req = 1'b0;
    test_reset();
    test_idle();
    test_ew_demand();
    test_both_demand();
`ifdef TLC_PED_EN
    test_ped_walk();
`else
    test_ped_ignored();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
